// File: rtl/dnn_result_writer_pkg.sv
// Shared definitions for the DNN result write-back engine.
//   LINE_W       : width of one result / cache line
//   STATUS_MAGIC : signature placed in bits [63:32] of the optional status line
//   state_e      : write-back controller states
package dnn_result_writer_pkg;

  localparam int          LINE_W       = 512;
  localparam logic [31:0] STATUS_MAGIC = 32'hD0E5_0001;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    WRITE,
    WAIT_DONE,
    STATUS,
    FINISH
  } state_e;

endpackage

// File: rtl/dnn_result_writer_result_fifo.sv
// Small synchronous FIFO holding result lines between the pipeline and the
// memory write port.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : line to store
//   pop_i        : discard head entry (ignored when empty)
//   head_o       : current head entry
//   full_o       : no free entry (evaluated before any same-cycle pop)
//   empty_o      : no valid entry
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/dnn_result_writer.sv
// DNN result write-back engine: accepts result lines from the pipeline
// handshake, buffers them in a small FIFO and issues them one at a time as
// sequential cache-line writes starting at base_addr.
// Optional feature macro: DNN_RESULT_WRITER_STATUS_EN -- after the last data
// line an extra status line (line count + magic) is written at
// base_addr + num_lines before done.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : job start pulse, honoured only when idle
//   base_addr, num_lines  : job parameters, latched on start
//   buffer_addr_valid     : host buffer address is programmed
//   dnn_out_vld/results   : pipeline result line offer
//   dnn_res_rdy           : result line accepted when high with dnn_out_vld
//   address/write_data    : registered write request fields
//   write_request_valid   : write request pending
//   write_done            : completion pulse for the pending write
//   busy                  : job in progress
//   done                  : one-cycle job completion pulse
module dnn_result_writer
  import dnn_result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  num_lines,
  input  logic              buffer_addr_valid,
  input  logic              dnn_out_vld,
  input  logic [LINE_W-1:0] dnn_results,
  output logic              dnn_res_rdy,
  output logic [31:0]       address,
  output logic [LINE_W-1:0] write_data,
  output logic              write_request_valid,
  input  logic              write_done,
  output logic              busy,
  output logic              done
);

`ifdef DNN_RESULT_WRITER_STATUS_EN
  localparam state_e AFTER_DATA = STATUS;
`else
  localparam state_e AFTER_DATA = FINISH;
`endif

  state_e            state_q;
  logic [31:0]       base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic [CNT_W-1:0]  wr_idx_q;
  logic [31:0]       address_q;
  logic [LINE_W-1:0] write_data_q;
  logic              wr_valid_q;
  logic              done_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [LINE_W-1:0] fifo_head;
  logic              push;
  logic              pop;

  // Lines are only taken once the buffer is known and never beyond the job size.
  assign dnn_res_rdy = (state_q != IDLE) && (state_q != WAIT_BUF) &&
                       !fifo_full && (acc_cnt_q < num_q);
  assign push        = dnn_out_vld && dnn_res_rdy;
  assign pop         = (state_q == WRITE) && !fifo_empty;

  assign busy                = (state_q != IDLE);
  assign done                = done_q;
  assign address             = address_q;
  assign write_data          = write_data_q;
  assign write_request_valid = wr_valid_q;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINE_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (dnn_results),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef DNN_RESULT_WRITER_STATUS_EN
  logic [LINE_W-1:0] status_line;

  always_comb begin
    status_line              = '0;
    status_line[CNT_W-1:0]   = num_q;
    status_line[63:32]       = STATUS_MAGIC;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      acc_cnt_q    <= '0;
      wr_idx_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      wr_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_lines;
            acc_cnt_q <= '0;
            wr_idx_q  <= '0;
            state_q   <= WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (buffer_addr_valid) begin
            state_q <= (num_q == '0) ? AFTER_DATA : WRITE;
          end
        end
        WRITE: begin
          if (!fifo_empty) begin
            address_q    <= base_q + 32'(wr_idx_q);
            write_data_q <= fifo_head;
            wr_valid_q   <= 1'b1;
            state_q      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (write_done) begin
            wr_valid_q <= 1'b0;
            wr_idx_q   <= wr_idx_q + CNT_W'(1);
            state_q    <= ((wr_idx_q + CNT_W'(1)) == num_q) ? AFTER_DATA : WRITE;
          end
        end
`ifdef DNN_RESULT_WRITER_STATUS_EN
        // First cycle issues the status write; write_done only counts once it is pending.
        STATUS: begin
          if (!wr_valid_q) begin
            address_q    <= base_q + 32'(num_q);
            write_data_q <= status_line;
            wr_valid_q   <= 1'b1;
          end else if (write_done) begin
            wr_valid_q <= 1'b0;
            state_q    <= FINISH;
          end
        end
`endif
        FINISH: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
